// File: rtl/div16s8_seq.sv
// rtl/div16s8_seq.sv - sequential signed 16/8 restoring divider with valid/ready handshakes
module div16s8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  R,
    output logic        ovf,
    output logic        dz
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [15:0] a_mag;
    logic [7:0]  b_mag;
    logic        s_a;
    logic        s_q;
    logic        dz_r;
    logic [7:0]  part;
    logic [4:0]  cnt;
    logic [15:0] qmag;

    logic [15:0] a_abs;
    logic [7:0]  b_abs;
    logic [8:0]  trial;
    logic        ge;
    logic [7:0]  diff;
    logic [7:0]  q_fix;
    logic [7:0]  r_fix;
    logic        ovf_fix;

    assign in_ready = (state == IDLE);

    // Unsigned negation keeps |-32768| = 0x8000 and |-128| = 0x80 without wrap.
    assign a_abs = A[15] ? (~A + 16'd1) : A;
    assign b_abs = B[7] ? (~B + 8'd1) : B;

    // The remainder stays below |B| <= 128, so 8 bits hold it between steps.
    assign trial = {part, a_mag[15]};
    assign ge    = (trial >= {1'b0, b_mag});
    assign diff  = trial[7:0] - b_mag;

    always_comb begin
        q_fix   = 8'h00;
        ovf_fix = 1'b0;
        if (dz_r) begin
            q_fix = s_a ? 8'h80 : 8'h7f;
        end else if (s_q) begin
            if (qmag > 16'd128) begin
                ovf_fix = 1'b1;
                q_fix   = 8'h80;
            end else begin
                q_fix = 8'd0 - qmag[7:0];
            end
        end else begin
            if (qmag > 16'd127) begin
                ovf_fix = 1'b1;
                q_fix   = 8'h7f;
            end else begin
                q_fix = qmag[7:0];
            end
        end
        r_fix = dz_r ? 8'h00 : (s_a ? (8'd0 - part) : part);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_mag     <= '0;
            s_a       <= 1'b0;
            s_q       <= 1'b0;
            dz_r      <= 1'b0;
            part      <= '0;
            cnt       <= '0;
            qmag      <= '0;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag <= a_abs;
                        b_mag <= b_abs;
                        s_a   <= A[15];
                        s_q   <= A[15] ^ B[7];
                        dz_r  <= (B == 8'd0);
                        part  <= '0;
                        cnt   <= '0;
                        qmag  <= '0;
                        state <= (B == 8'd0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    part  <= ge ? diff : trial[7:0];
                    qmag  <= {qmag[14:0], ge};
                    a_mag <= {a_mag[14:0], 1'b0};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd15) state <= FIX;
                end
                FIX: begin
                    Q         <= q_fix;
                    R         <= r_fix;
                    ovf       <= ovf_fix;
                    dz        <= dz_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div16s8_seq.sv
// tb/tb_div16s8_seq.sv - directed self-checking bench for div16s8_seq
module tb_div16s8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;
    logic        dz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div16s8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .ovf       (ovf),
        .dz        (dz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; the accept edge counts as edge 1.
    task automatic wait_result(input string tag, input int exp_lat, input logic [7:0] eq,
                               input logic [7:0] er, input logic eovf, input logic edz);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, Q, eq);
        chk({tag, "_r"}, R, er);
        chk({tag, "_ovf"}, ovf, eovf);
        chk({tag, "_dz"}, dz, edz);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic eovf, input logic edz);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(tag, exp_lat, eq, er, eovf, edz);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, out_valid, 1'b0);
        chk({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_q", Q, 8'h00);
        chk("rst_r", R, 8'h00);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_dz", dz, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1000 / -9 = -111 rem 1
        run_op("pos_neg", 16'd1000, -8'sd9, 18, 8'h91, 8'h01, 1'b0, 1'b0);
        consume("pos_neg");
        // -16384 / -128 = 128 -> saturates to 127
        run_op("bnd_sat", -16'sd16384, 8'h80, 18, 8'h7f, 8'h00, 1'b1, 1'b0);
        consume("bnd_sat");
        // 16384 / -128 = -128 exactly representable
        run_op("bnd_min", 16'd16384, 8'h80, 18, 8'h80, 8'h00, 1'b0, 1'b0);
        consume("bnd_min");
        // -32768 / -1 = 32768 -> 127
        run_op("ext_m1", 16'h8000, 8'hff, 18, 8'h7f, 8'h00, 1'b1, 1'b0);
        consume("ext_m1");
        // -32768 / 127 = -258 rem -2 -> -128
        run_op("ext_127", 16'h8000, 8'd127, 18, 8'h80, 8'hfe, 1'b1, 1'b0);
        consume("ext_127");
        run_op("dz_pos", 16'd5, 8'd0, 2, 8'h7f, 8'h00, 1'b0, 1'b1);
        consume("dz_pos");
        run_op("dz_neg", -16'sd5, 8'd0, 2, 8'h80, 8'h00, 1'b0, 1'b1);
        consume("dz_neg");

        // -1000 / 9 = -111 rem -1, then hold under backpressure with a pending request
        run_op("bp", -16'sd1000, 8'd9, 18, 8'h91, 8'hff, 1'b0, 1'b0);
        @(negedge clk);
        A = 16'd100;
        B = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_q", Q, 8'h91);
            chk("bp_hold_r", R, 8'hff);
            chk("bp_hold_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accept", in_ready, 1'b0);
        wait_result("bp2", 18, 8'd33, 8'd1, 1'b0, 1'b0);
        consume("bp2");

        // Reset at CALC step 7, with a competing in_valid that must be ignored
        @(negedge clk);
        A = 16'd1000;
        B = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_q", Q, 8'h00);
        chk("mid_rst_r", R, 8'h00);
        chk("mid_rst_dz", dz, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", in_ready, 1'b1);
        chk("post_rst_no_valid", out_valid, 1'b0);
        // -77 / 7 = -11 rem 0
        run_op("after_rst", -16'sd77, 8'd7, 18, 8'hf5, 8'h00, 1'b0, 1'b0);
        consume("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
